// File: rtl/inst_mem_resp_if.sv
// Fetch request/response bundle between the PC block (master) and the
// instruction memory responder (slave).
//   req_valid/req_ready/req_addr      : fetch request handshake, byte address
//   resp_valid/resp_ready             : in-order response handshake
//   resp_addr/resp_inst/resp_fault    : returned address, word and fault flag
interface inst_mem_resp_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_addr;
   logic [31:0] resp_inst;
   logic        resp_fault;

   modport master (
      output req_valid, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_addr, resp_inst, resp_fault
   );

   modport slave (
      input  req_valid, req_addr, resp_ready,
      output req_ready, resp_valid, resp_addr, resp_inst, resp_fault
   );
endinterface

// File: rtl/inst_mem_resp.sv
// Instruction memory responder for the IF stage.
// Accepts fetch requests, reads a word-addressed RAM through a fixed-latency
// pipe and returns results in request order through a small response FIFO.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : drop every in-flight and queued fetch
//   prog_we/addr/data     : program-load write port (byte address, word data)
//   bus (slave)           : fetch request / response handshake bundle
module inst_mem_resp #(
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned RESP_DEPTH = 4,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          prog_we,
   input  logic [31:0]   prog_addr,
   input  logic [31:0]   prog_data,
   inst_mem_resp_if.slave bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
   localparam logic [29:0] DEPTH_W = 30'(DEPTH);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
      logic        fault;
   } entry_t;

   logic [31:0]        mem [DEPTH];
   logic [LATENCY-1:0] pipe_v;
   entry_t             pipe_e [LATENCY];
   entry_t             fifo [RESP_DEPTH];
   logic [PW-1:0]      wptr, rptr;
   logic [CW-1:0]      count, occ;

   logic               ready_c, resp_valid_c, accept, pop, push, fault_c;
   logic [AW-1:0]      rd_idx;
   entry_t             new_e;
   entry_t             head;
   logic               unused_prog_lsb;

   assign unused_prog_lsb = ^prog_addr[1:0];

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Handshake qualifiers; ready depends only on registered occupancy and flush
   assign ready_c      = (occ < CW'(RESP_DEPTH)) && !flush;
   assign resp_valid_c = (count != '0);
   assign accept       = bus.req_valid && ready_c;
   assign pop          = resp_valid_c && bus.resp_ready;
   assign push         = pipe_v[LATENCY-1];

   assign fault_c = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:2] >= DEPTH_W);
   assign rd_idx  = bus.req_addr[AW+1:2];

   // Stage-1 payload; faulting fetches never touch the RAM
   always_comb begin
      new_e       = '0;
      new_e.addr  = bus.req_addr;
      new_e.fault = fault_c;
      new_e.inst  = fault_c ? NOP_INST : mem[rd_idx];
   end

   // Program-load port; RAM is never reset
   always_ff @(posedge clk) begin
      if (prog_we && (prog_addr[31:2] < DEPTH_W)) begin
         mem[prog_addr[AW+1:2]] <= prog_data;
      end
   end

   // Payload datapath: pipe shifts every cycle, stale entries are masked by valids
   always_ff @(posedge clk) begin
      pipe_e[0] <= new_e;
      for (int i = 1; i < int'(LATENCY); i++) begin
         pipe_e[i] <= pipe_e[i-1];
      end
      if (push) begin
         fifo[wptr] <= pipe_e[LATENCY-1];
      end
   end

   // Control state: pipe valids, FIFO pointers/count and occupancy
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         pipe_v <= '0;
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
         occ    <= '0;
      end else begin
         pipe_v[0] <= accept;
         for (int i = 1; i < int'(LATENCY); i++) begin
            pipe_v[i] <= pipe_v[i-1];
         end

         if (push) wptr <= ptr_next(wptr);
         if (pop)  rptr <= ptr_next(rptr);

         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         case ({accept, pop})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: occ <= occ;
         endcase

         // The occupancy limit guarantees a push never lands on a full FIFO
         assert (!(push && !pop && (count == CW'(RESP_DEPTH))));
      end
   end

   // Response outputs are zeroed whenever the FIFO is empty
   assign head            = fifo[rptr];
   assign bus.req_ready   = ready_c;
   assign bus.resp_valid  = resp_valid_c;
   assign bus.resp_addr   = resp_valid_c ? head.addr  : 32'h0;
   assign bus.resp_inst   = resp_valid_c ? head.inst  : 32'h0;
   assign bus.resp_fault  = resp_valid_c ? head.fault : 1'b0;
endmodule

// File: doc/inst_mem_resp.md
Name: inst_mem_resp

Overview:
- Responder side of the IF-stage fetch interface. The PC block initiates fetch addresses; this block accepts them and returns instruction words.
- Accepts fetch requests through a valid/ready handshake and reads a word-addressed instruction RAM through a fixed-latency read pipe.
- Queues results in a response FIFO and returns them in order with address, instruction and fault flag.
- The flush input discards everything in flight on a branch redirect.

Parameters:
DEPTH, 1024, instruction words held; word index = addr[31:2]
LATENCY, 2, read-pipe stages (>=1) from accept to FIFO entry
RESP_DEPTH, 4, response FIFO entries; also the max outstanding requests
NOP_INST, 32'h00000013, instruction returned on fault

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
req_valid  in  1  fetch request present
req_ready  out  1  request accepted this cycle when both high
req_addr  in  32  byte fetch address
flush  in  1  discard all in-flight and queued responses
resp_valid  out  1  FIFO head valid
resp_ready  in  1  consumer takes head when both high
resp_addr  out  32  address of returned word
resp_inst  out  32  instruction word
resp_fault  out  1  misaligned or out-of-range fetch
prog_we  in  1  program-load write enable
prog_addr  in  32  byte address for load (bits [1:0] ignored)
prog_data  in  32  word to load

Behaviour:
- Reset (rst high at posedge): pipe valids cleared; FIFO pointers and count set to 0; occupancy 0.
  - Outputs after reset: req_ready=1, resp_valid=0, resp_addr=0, resp_inst=0, resp_fault=0.
  - RAM contents are not reset.
  - Reset mid-operation drops all outstanding requests; no response for them ever appears.
- Occupancy: occ = (valid pipe stages) + (FIFO count), held as a registered counter.
  - Incremented on accept; decremented on pop.
  - Accept and pop in the same cycle leave occ unchanged.
- req_ready = (occ < RESP_DEPTH) and not flush.
  - Combinational from registered occ and flush only; no dependence on resp_ready.
- Accept at edge E (req_valid & req_ready):
  - Stage 1 captures addr, the RAM read result, and fault.
  - fault = (req_addr[1:0] != 0) or (req_addr[31:2] >= DEPTH).
  - On fault, the data field is NOP_INST.
- Pipe advance: stages shift every cycle unconditionally (no stall). Stage LATENCY writes the FIFO at the next edge.
  - FIFO can never overflow because of the occ limit; the verifier asserts this.
- Latency: a request accepted at edge E makes resp_valid high in the cycle after edge E+LATENCY-1+1.
  - With LATENCY=2, accept at edge 0 gives resp_valid=1 after edge 2.
  - Back-to-back accepts give back-to-back responses.
- Response outputs:
  - resp_valid = FIFO non-empty.
  - resp_addr, resp_inst, resp_fault come from the FIFO head.
  - All three are forced to 0 when resp_valid=0.
  - Pop on resp_valid & resp_ready. Order is strictly request order.
- FIFO pointers: log2(RESP_DEPTH) bits, wrap modulo RESP_DEPTH.
  - Full/empty are decided by the count, not by pointer equality.
  - Simultaneous push and pop when full is legal; count unchanged.
- flush high at posedge:
  - Clears all pipe valids, FIFO count/pointers and occ to 0.
  - Any request or pop in that cycle is ignored (req_ready is already 0).
  - The cycle after flush: resp_valid=0, req_ready=1.
  - flush has priority below rst only.
- Program port: on prog_we at posedge, RAM[prog_addr[31:2]] <= prog_data.
  - Writes with index >= DEPTH are ignored.
  - A fetch accepted in the same cycle to the same word returns the old data (read-before-write).
- Widths: addr compare is unsigned. Only bits [clog2(DEPTH)+1:2] index the RAM.

Test Plan:
1. Load RAM[0..3]=0x00500093,0x00100113,0x002081B3,0x0000006F via prog port; request 0x0,0x4,0x8,0xC back-to-back with resp_ready=1 → four responses on consecutive cycles, first appearing after edge 2, matching words and addresses, fault=0.
2. resp_ready=0, issue requests continuously → exactly 4 accepted, then req_ready=0. Raise resp_ready for one cycle → one pop, req_ready=1 next cycle, one more accept.
3. Request 0x6 and 0x1000 (DEPTH=1024) → both return resp_fault=1, resp_inst=0x00000013, correct resp_addr.
4. With 3 requests in flight (2 in FIFO, 1 in pipe), assert flush one cycle → the following cycle resp_valid=0 and req_ready=1; a new request to 0x8 returns only 0x002081B3, with no stale responses.
5. Same cycle: prog_we to 0x0 with 0xDEADBEEF plus fetch of 0x0 → returns 0x00500093; a subsequent fetch of 0x0 returns 0xDEADBEEF.
6. Assert rst with FIFO full and pipe busy → next cycle resp_valid=0, all resp fields 0, req_ready=1; RAM content retained.
